// File: rtl/elevator_keys_pkg.sv
`default_nettype none
// ============================================================================
// elevator_keys_pkg : key codes, key-vector layout and FSM state encoding
//                     shared by the keypad encoder and the management FSM.
// Revision: 1.0
// ============================================================================
package elevator_keys_pkg;

    localparam logic [3:0] KEY_STAR     = 4'd11;
    localparam logic [3:0] KEY_HASH     = 4'd12;
    localparam logic [3:0] KEY_STARHASH = 4'd13;

    localparam int         KEY_COUNT = 12;
    localparam logic [3:0] IDX_STAR  = 4'd9;
    localparam logic [3:0] IDX_HASH  = 4'd11;
    localparam logic [11:0] VEC_STARHASH = 12'hA00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PEND   = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;
    localparam logic [1:0] ST_REJECT = 2'd3;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_DIGIT,
        CLS_STAR,
        CLS_HASH,
        CLS_CHORD,
        CLS_INVALID
    } key_class_t;

    // Key index is 3*row + col; rows 0..2 carry digits 1..9, row 3 is * 0 #.
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd9:    code = KEY_STAR;
            4'd10:   code = 4'd0;
            4'd11:   code = KEY_HASH;
            default: code = idx + 4'd1;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// keypad_debounce : generic N-bit vector debouncer, accepts a vector after it
//                   has been identical over DEBOUNCE_SCANS consecutive ticks.
// Revision: 1.0
// ============================================================================
module keypad_debounce #(
    parameter int WIDTH          = 12,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);
    localparam int             CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] held;
    logic [CNT_W-1:0] count;
    logic             same;
    logic             accept;

    assign same   = (raw == prev);
    assign accept = tick && same && (count >= CNT_LAST);
    // Look-ahead: the accepted vector is visible in the tick cycle itself.
    assign stable = accept ? raw : held;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= '0;
            held  <= '0;
            count <= '0;
        end else begin
            held <= stable;
            if (tick) begin
                prev <= raw;
                if (!same) begin
                    count <= '0;
                end else if (count < CNT_MAX) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
// keypad_encoder : scans the 4x3 keypad, debounces it and emits one key code
//                  per key action with a single-cycle valid strobe.
// Revision: 1.0
// ============================================================================
module keypad_encoder
    import elevator_keys_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int CHORD_SCANS    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [3:0] ROW,
    input  logic [2:0] COL,
    output logic [3:0] BCD_out,
    output logic       BCD_valid,
    output logic       KEY_held
);
    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int               CH_W     = $clog2(CHORD_SCANS + 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHORD_SCANS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [11:0]      raw;
    logic [11:0]      raw_now;
    logic [11:0]      deb;
    logic             row_end;
    logic             scan_tick;

    assign row_end   = (div_cnt == DIV_LAST);
    assign scan_tick = row_end && (row_idx == 2'd3);
    assign ROW       = ~(4'b0001 << row_idx);

    // raw_now already holds the row being sampled, so the tick sees a full scan.
    always_comb begin
        raw_now = raw;
        if (row_end) begin
            case (row_idx)
                2'd0:    raw_now[2:0]  = ~COL;
                2'd1:    raw_now[5:3]  = ~COL;
                2'd2:    raw_now[8:6]  = ~COL;
                default: raw_now[11:9] = ~COL;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
            row_idx <= '0;
            raw     <= '0;
        end else begin
            raw <= raw_now;
            if (row_end) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    keypad_debounce #(
        .WIDTH          (KEY_COUNT),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk    (CLK),
        .rst    (RST),
        .tick   (scan_tick),
        .raw    (raw_now),
        .stable (deb)
    );

    logic [3:0] n_keys;
    logic [3:0] key_idx;
    key_class_t cls;

    always_comb begin
        n_keys  = '0;
        key_idx = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (deb[i]) begin
                n_keys  = n_keys + 4'd1;
                key_idx = 4'(i);
            end
        end
        if (n_keys == 4'd0)             cls = CLS_NONE;
        else if (deb == VEC_STARHASH)   cls = CLS_CHORD;
        else if (n_keys != 4'd1)        cls = CLS_INVALID;
        else if (key_idx == IDX_STAR)   cls = CLS_STAR;
        else if (key_idx == IDX_HASH)   cls = CLS_HASH;
        else                            cls = CLS_DIGIT;
    end

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [3:0]      pend_code;
    logic [3:0]      pend_next;
    logic [CH_W-1:0] chord_cnt;
    logic [CH_W-1:0] chord_next;
    logic            emit;
    logic [3:0]      emit_code;
    logic            pend_match;

    assign pend_match = ((cls == CLS_STAR) && (pend_code == KEY_STAR)) ||
                        ((cls == CLS_HASH) && (pend_code == KEY_HASH));

    always_comb begin
        state_next = state;
        pend_next  = pend_code;
        chord_next = chord_cnt;
        emit       = 1'b0;
        emit_code  = pend_code;
        if (scan_tick) begin
            case (state)
                ST_IDLE: begin
                    case (cls)
                        CLS_DIGIT: begin
                            emit       = 1'b1;
                            emit_code  = key_code(key_idx);
                            state_next = ST_HELD;
                        end
                        CLS_STAR, CLS_HASH: begin
                            pend_next  = (cls == CLS_STAR) ? KEY_STAR : KEY_HASH;
                            chord_next = '0;
                            state_next = ST_PEND;
                        end
                        CLS_CHORD: begin
                            emit       = 1'b1;
                            emit_code  = KEY_STARHASH;
                            state_next = ST_HELD;
                        end
                        CLS_INVALID: state_next = ST_REJECT;
                        default: ;
                    endcase
                end
                ST_PEND: begin
                    if (cls == CLS_CHORD) begin
                        emit       = 1'b1;
                        emit_code  = KEY_STARHASH;
                        state_next = ST_HELD;
                    end else if (cls == CLS_NONE) begin
                        emit       = 1'b1;
                        state_next = ST_IDLE;
                    end else if (!pend_match) begin
                        state_next = ST_REJECT;
                    end else if (chord_cnt >= CH_LAST) begin
                        // Partner never arrived: this tick is the CHORD_SCANS-th.
                        emit       = 1'b1;
                        state_next = ST_HELD;
                    end else begin
                        chord_next = chord_cnt + CH_W'(1);
                    end
                end
                default: begin
                    if (cls == CLS_NONE) state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            pend_code <= '0;
            chord_cnt <= '0;
            BCD_out   <= '0;
            BCD_valid <= 1'b0;
            KEY_held  <= 1'b0;
        end else begin
            state     <= state_next;
            pend_code <= pend_next;
            chord_cnt <= chord_next;
            BCD_valid <= emit;
            KEY_held  <= |deb;
            if (emit) BCD_out <= emit_code;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// Testbench for keypad_encoder: a keypad contact model drives COL, and a
// scan-level behavioural model predicts every emission and held flag.
module tb_keypad_encoder;
    localparam int SDIV  = 4;
    localparam int DEB   = 3;
    localparam int CHORD = 8;
    localparam int SCAN  = 4 * SDIV;
    localparam int M_IDLE = 0, M_PEND = 1, M_HELD = 2, M_REJECT = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ROW;
    logic [2:0] COL;
    logic [3:0] BCD_out;
    logic       BCD_valid;
    logic       KEY_held;
    logic [11:0] pressed = '0;

    int checks   = 0;
    int failures = 0;

    keypad_encoder #(
        .SCAN_DIV       (SDIV),
        .DEBOUNCE_SCANS (DEB),
        .CHORD_SCANS    (CHORD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ROW       (ROW),
        .COL       (COL),
        .BCD_out   (BCD_out),
        .BCD_valid (BCD_valid),
        .KEY_held  (KEY_held)
    );

    always #5 CLK = ~CLK;

    // A pressed key shorts its row to its column.
    always_comb begin
        COL = 3'b111;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[3*r+c] && !ROW[r]) COL[c] = 1'b0;
            end
        end
    end

    // ---------------- behavioural model, one call per full scan -------------
    logic [11:0] hist[$];
    logic [11:0] mdeb;
    int          mstate;
    int          mpend;
    int          mcnt;
    logic [3:0]  mlast;

    function automatic int code_of(input int idx);
        if (idx < 9)   return idx + 1;
        if (idx == 9)  return 11;
        if (idx == 10) return 0;
        return 12;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(12'h000);
        mdeb   = '0;
        mstate = M_IDLE;
        mpend  = 0;
        mcnt   = 0;
        mlast  = '0;
    endtask

    task automatic model_scan(input logic [11:0] rawv, output int emit);
        int n;
        int idx;
        logic [11:0] pend_vec;
        hist.push_back(rawv);
        while (hist.size() > DEB + 1) void'(hist.pop_front());
        if (hist.size() == DEB + 1) begin
            bit all_same = 1'b1;
            foreach (hist[k]) if (hist[k] != rawv) all_same = 1'b0;
            if (all_same) mdeb = rawv;
        end
        n   = $countones(mdeb);
        idx = 0;
        for (int i = 0; i < 12; i++) if (mdeb[i]) idx = i;
        pend_vec = (mpend == 11) ? 12'h200 : 12'h800;
        emit = -1;
        case (mstate)
            M_IDLE: begin
                if (n == 0) begin
                end else if (mdeb == 12'hA00) begin
                    emit = 13; mstate = M_HELD;
                end else if (n == 1 && (idx == 9 || idx == 11)) begin
                    mpend = (idx == 9) ? 11 : 12; mcnt = 0; mstate = M_PEND;
                end else if (n == 1) begin
                    emit = code_of(idx); mstate = M_HELD;
                end else begin
                    mstate = M_REJECT;
                end
            end
            M_PEND: begin
                if (mdeb == 12'hA00) begin
                    emit = 13; mstate = M_HELD;
                end else if (n == 0) begin
                    emit = mpend; mstate = M_IDLE;
                end else if (mdeb != pend_vec) begin
                    mstate = M_REJECT;
                end else begin
                    mcnt++;
                    if (mcnt >= CHORD) begin
                        emit = mpend; mstate = M_HELD;
                    end
                end
            end
            default: if (n == 0) mstate = M_IDLE;
        endcase
        if (emit >= 0) mlast = 4'(emit);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one key vector for one full scan, aligned to the scanner's row 0.
    task automatic run_scan(input logic [11:0] vec, output int seen);
        int emit;
        seen    = 0;
        pressed = vec;
        model_scan(vec, emit);
        for (int i = 1; i <= SCAN; i++) begin
            @(posedge CLK); #1;
            if (BCD_valid) seen++;
            if (i < SCAN) check("valid_between_ticks", BCD_valid, 0);
        end
        check("valid_after_tick", BCD_valid, (emit >= 0));
        check("bcd_out", BCD_out, mlast);
        check("key_held", KEY_held, (mdeb != 0));
        check("row_phase", ROW, 4'b1110);
    endtask

    task automatic run_seg(input logic [11:0] vec, input int scans, output int emits);
        int s;
        emits = 0;
        for (int k = 0; k < scans; k++) begin
            run_scan(vec, s);
            emits += s;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_valid", BCD_valid, 0);
        check("rst_bcd", BCD_out, 0);
        check("rst_held", KEY_held, 0);
        check("rst_row", ROW, 4'b1110);
        RST = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [11:0] vec;
        int          scans;
        int          exp_emits;
        logic [3:0]  exp_code;
    } seg_t;

    seg_t tbl[$];

    task automatic add_seg(input logic [11:0] v, input int sc, input int em, input logic [3:0] cd);
        seg_t s;
        s.vec = v; s.scans = sc; s.exp_emits = em; s.exp_code = cd;
        tbl.push_back(s);
    endtask

    initial begin
        int em;
        model_reset();

        // Directed key scenarios: {vector, scans, emissions, code}.
        add_seg(12'h010, 10, 1, 4'd5);    // '5'
        add_seg(12'h000,  6, 0, 4'd0);
        add_seg(12'h200,  3, 0, 4'd0);    // '*' then '#' joins
        add_seg(12'hA00, 10, 1, 4'd13);
        add_seg(12'h000,  6, 0, 4'd0);
        add_seg(12'h800, 20, 1, 4'd12);   // lone '#'
        add_seg(12'h000,  6, 0, 4'd0);
        for (int t = 0; t < 3; t++) begin // bouncing '7'
            add_seg(12'h040, 2, 0, 4'd0);
            add_seg(12'h000, 2, 0, 4'd0);
        end
        add_seg(12'h040,  8, 1, 4'd7);
        add_seg(12'h000,  6, 0, 4'd0);
        add_seg(12'h003,  8, 0, 4'd0);    // '1'+'2' rejected
        add_seg(12'h000,  6, 0, 4'd0);
        add_seg(12'h400,  8, 1, 4'd0);    // '0'
        add_seg(12'h000,  6, 0, 4'd0);

        repeat (3) @(posedge CLK);
        #1;
        check("init_valid", BCD_valid, 0);
        check("init_bcd", BCD_out, 0);
        check("init_held", KEY_held, 0);
        check("init_row", ROW, 4'b1110);
        RST = 1'b0;

        foreach (tbl[i]) begin
            run_seg(tbl[i].vec, tbl[i].scans, em);
            check($sformatf("seg%0d_emits", i), em, tbl[i].exp_emits);
            if (tbl[i].exp_emits > 0) check($sformatf("seg%0d_code", i), BCD_out, tbl[i].exp_code);
        end

        // Reset while the strobe is high.
        run_seg(12'h004, 4, em);
        check("strobe_before_reset", BCD_valid, 1);
        do_reset();
        run_seg(12'h000, 6, em);
        check("no_emit_after_reset", em, 0);

        // Reset mid-scan while '*' is pending; '*' stays held across it.
        run_seg(12'h200, 6, em);
        check("pend_no_emit", em, 0);
        pressed = 12'h200;
        repeat (7) @(posedge CLK);
        #1;
        do_reset();
        run_seg(12'h200, 20, em);
        check("star_after_reset_emits", em, 1);
        check("star_after_reset_code", BCD_out, 4'd11);
        run_seg(12'h000, 6, em);

        // Randomized key activity checked scan by scan against the model.
        for (int r = 0; r < 30; r++) begin
            logic [11:0] v;
            int sel;
            sel = int'($urandom_range(0, 20));
            if (sel < 12)       v = 12'(1) << sel;
            else if (sel == 12) v = 12'hA00;
            else if (sel == 13) v = 12'h003;
            else if (sel == 14) v = 12'h220;
            else                v = 12'h000;
            run_seg(v, int'($urandom_range(1, 12)), em);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
